remote_load_resp_unit: RTL and testbench

- Receive end of the remote load path for one vanilla core.
- Accepts load responses returned from the network TX/RX endpoint and buffers them in a small FIFO.
- Formats each response using the load_info captured when the request was issued: byte/half extraction plus sign/zero extension.
- Steers the result to one of three sinks: integer RF writeback, FP RF writeback, or icache refill. Also tracks outstanding remote loads so the issuing LSU can throttle.

---
 rtl/remote_load_resp_unit_if.sv | 48 ++++
 rtl/remote_load_resp_unit.sv | 144 ++++++++++++++
 tb/tb_remote_load_resp_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/remote_load_resp_unit_if.sv
// Handshake bundle for the remote load receive path: network response in, LSU throttle, and the three result sinks.
interface remote_load_resp_unit_if #(
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 5,
   parameter int cnt_width_p      = 5
);
   logic                        resp_v_i;
   logic [data_width_p-1:0]     resp_data_i;
   logic [6:0]                  resp_load_info_i;
   logic [reg_addr_width_p-1:0] resp_reg_id_i;
   logic                        resp_ready_o;

   logic                        load_sent_i;

   logic                        int_wb_v_o;
   logic [reg_addr_width_p-1:0] int_wb_rd_o;
   logic [data_width_p-1:0]     int_wb_data_o;
   logic                        int_wb_yumi_i;

   logic                        float_wb_v_o;
   logic [reg_addr_width_p-1:0] float_wb_rd_o;
   logic [data_width_p-1:0]     float_wb_data_o;
   logic                        float_wb_yumi_i;

   logic                        icache_v_o;
   logic [data_width_p-1:0]     icache_data_o;
   logic                        icache_yumi_i;

   logic [cnt_width_p-1:0]      outstanding_o;
   logic                        outstanding_full_o;
   logic                        idle_o;

   modport slave (
      input  resp_v_i, resp_data_i, resp_load_info_i, resp_reg_id_i, load_sent_i,
             int_wb_yumi_i, float_wb_yumi_i, icache_yumi_i,
      output resp_ready_o, int_wb_v_o, int_wb_rd_o, int_wb_data_o,
             float_wb_v_o, float_wb_rd_o, float_wb_data_o, icache_v_o, icache_data_o,
             outstanding_o, outstanding_full_o, idle_o
   );

   modport master (
      output resp_v_i, resp_data_i, resp_load_info_i, resp_reg_id_i, load_sent_i,
             int_wb_yumi_i, float_wb_yumi_i, icache_yumi_i,
      input  resp_ready_o, int_wb_v_o, int_wb_rd_o, int_wb_data_o,
             float_wb_v_o, float_wb_rd_o, float_wb_data_o, icache_v_o, icache_data_o,
             outstanding_o, outstanding_full_o, idle_o
   );
endinterface

// File: rtl/remote_load_resp_unit.sv
// Remote load receive unit: buffers responses, formats int loads, steers to int RF / FP RF / icache, counts loads in flight.
// Head is visible the cycle after enqueue; resp_ready_o drops while the FIFO is full, sinks stall the head via yumi.
module remote_load_resp_unit #(
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 5,
   parameter int fifo_els_p       = 2,
   parameter int max_out_p        = 16
) (
   input  logic clk_i,
   input  logic reset_n_i,
   remote_load_resp_unit_if.slave bus
);
   localparam int ptr_width_lp = $clog2(fifo_els_p);
   localparam int cnt_width_lp = $clog2(max_out_p + 1);
   localparam int half_lp      = data_width_p / 2;

   typedef struct packed {
      logic       float_wb;
      logic       icache_fetch;
      logic       is_unsigned_op;
      logic       is_byte_op;
      logic       is_hex_op;
      logic [1:0] part_sel;
   } load_info_t;

   typedef struct packed {
      logic [data_width_p-1:0]     data;
      load_info_t                  info;
      logic [reg_addr_width_p-1:0] reg_id;
   } entry_t;

   typedef logic [ptr_width_lp:0] ptr_t;

   entry_t                  mem_q [fifo_els_p];
   entry_t                  mem_d [fifo_els_p];
   ptr_t                    wr_ptr_q, wr_ptr_d;
   ptr_t                    rd_ptr_q, rd_ptr_d;
   logic [cnt_width_lp-1:0] out_cnt_q, out_cnt_d;

   entry_t                  head;
   logic                    empty, full, head_v;
   logic                    is_icache, is_float, is_int, x0_drop;
   logic                    sel_yumi, enq, deq, resp_ready;
   logic [7:0]              byte_sel;
   logic [half_lp-1:0]      hex_sel;
   logic [data_width_p-1:0] int_data;

   // Pointer wraps at fifo_els_p and flips the lap bit so full and empty stay distinguishable.
   function automatic ptr_t ptr_inc(input ptr_t p);
      ptr_t r;
      if (p[ptr_width_lp-1:0] == ptr_width_lp'(fifo_els_p - 1)) begin
         r = {~p[ptr_width_lp], {ptr_width_lp{1'b0}}};
      end else begin
         r = p + ptr_t'(1);
      end
      return r;
   endfunction

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ptr_width_lp] != rd_ptr_q[ptr_width_lp]) &&
                  (wr_ptr_q[ptr_width_lp-1:0] == rd_ptr_q[ptr_width_lp-1:0]);
   assign head  = mem_q[rd_ptr_q[ptr_width_lp-1:0]];

   always_comb begin
      head_v     = reset_n_i & ~empty;
      resp_ready = reset_n_i & ~full;
      is_icache  = head.info.icache_fetch;
      is_float   = ~head.info.icache_fetch & head.info.float_wb;
      is_int     = ~head.info.icache_fetch & ~head.info.float_wb;
      x0_drop    = head_v & is_int & (head.reg_id == '0);
      sel_yumi   = is_icache ? bus.icache_yumi_i :
                   is_float  ? bus.float_wb_yumi_i : bus.int_wb_yumi_i;
      enq        = bus.resp_v_i & resp_ready;
      deq        = head_v & (x0_drop | sel_yumi);
   end

   always_comb begin
      byte_sel = head.data[{head.info.part_sel, 3'b000} +: 8];
      hex_sel  = head.info.part_sel[1] ? head.data[data_width_p-1:half_lp] : head.data[half_lp-1:0];
      if (head.info.is_byte_op) begin
         int_data = {{(data_width_p-8){~head.info.is_unsigned_op & byte_sel[7]}}, byte_sel};
      end else if (head.info.is_hex_op) begin
         int_data = {{(data_width_p-half_lp){~head.info.is_unsigned_op & hex_sel[half_lp-1]}}, hex_sel};
      end else begin
         int_data = head.data;
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_cnt_d = out_cnt_q;
      if (enq) begin
         mem_d[wr_ptr_q[ptr_width_lp-1:0]].data   = bus.resp_data_i;
         mem_d[wr_ptr_q[ptr_width_lp-1:0]].info   = load_info_t'(bus.resp_load_info_i);
         mem_d[wr_ptr_q[ptr_width_lp-1:0]].reg_id = bus.resp_reg_id_i;
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Send and return in the same cycle cancel; illegal over/underflow saturates.
      if (bus.load_sent_i && !enq && out_cnt_q != cnt_width_lp'(max_out_p)) begin
         out_cnt_d = out_cnt_q + cnt_width_lp'(1);
      end else if (enq && !bus.load_sent_i && out_cnt_q != '0) begin
         out_cnt_d = out_cnt_q - cnt_width_lp'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (!reset_n_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign bus.resp_ready_o       = resp_ready;
   assign bus.icache_v_o         = head_v & is_icache;
   assign bus.icache_data_o      = head.data;
   assign bus.float_wb_v_o       = head_v & is_float;
   assign bus.float_wb_rd_o      = head.reg_id;
   assign bus.float_wb_data_o    = head.data;
   assign bus.int_wb_v_o         = head_v & is_int & (head.reg_id != '0);
   assign bus.int_wb_rd_o        = head.reg_id;
   assign bus.int_wb_data_o      = int_data;
   assign bus.outstanding_o      = out_cnt_q;
   assign bus.outstanding_full_o = (out_cnt_q == cnt_width_lp'(max_out_p));
   assign bus.idle_o             = empty & (out_cnt_q == '0);

   a_int_yumi:    assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.int_wb_yumi_i |-> bus.int_wb_v_o);
   a_float_yumi:  assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.float_wb_yumi_i |-> bus.float_wb_v_o);
   a_icache_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.icache_yumi_i |-> bus.icache_v_o);
   a_cnt_over:    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   (bus.load_sent_i && !enq) |-> (out_cnt_q != cnt_width_lp'(max_out_p)));
   a_cnt_under:   assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   (enq && !bus.load_sent_i) |-> (out_cnt_q != '0));
endmodule

// File: tb/tb_remote_load_resp_unit.sv
// Bench for remote_load_resp_unit: directed scenarios plus a randomized run against a queue-based reference.
module tb_remote_load_resp_unit;
   localparam int max_out = 16;
   localparam int cw      = $clog2(max_out + 1);

   // load_info = {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0]}
   localparam logic [6:0] info_word = 7'b0000000;

   typedef struct {
      logic [31:0] data;
      logic [6:0]  info;
      logic [4:0]  rd;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   remote_load_resp_unit_if #(.data_width_p(32), .reg_addr_width_p(5), .cnt_width_p(cw)) bus ();

   remote_load_resp_unit #(
      .data_width_p(32), .reg_addr_width_p(5), .fifo_els_p(2), .max_out_p(max_out)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want $finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_fmt(input logic [31:0] d, input logic [6:0] info);
      logic [31:0] v;
      int          width;
      if (info[3]) begin
         v = (d >> (8 * info[1:0])) & 32'hFF;
         width = 8;
      end else if (info[2]) begin
         v = info[1] ? (d >> 16) : (d & 32'hFFFF);
         width = 16;
      end else begin
         return d;
      end
      if (!info[4] && v[width-1]) v = v | (32'hFFFFFFFF << width);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.resp_v_i = 0; bus.resp_data_i = '0; bus.resp_load_info_i = '0; bus.resp_reg_id_i = '0;
      bus.load_sent_i = 0; bus.int_wb_yumi_i = 0; bus.float_wb_yumi_i = 0; bus.icache_yumi_i = 0;
   endtask

   task automatic send_loads(input int n);
      bus.load_sent_i = 1;
      repeat (n) step();
      bus.load_sent_i = 0;
   endtask

   task automatic push(input logic [31:0] d, input logic [6:0] info, input logic [4:0] rd, input string name);
      int t = 0;
      bus.resp_v_i = 1; bus.resp_data_i = d; bus.resp_load_info_i = info; bus.resp_reg_id_i = rd;
      while (bus.resp_ready_o !== 1'b1 && t < 50) begin step(); t++; end
      checks++; if (t >= 50) begin errors++; $display("FAIL %s_accept: resp_ready_o got %b want 1", name, bus.resp_ready_o); end
      step();
      bus.resp_v_i = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset_n = 0;
      step();
      checks++; if (bus.resp_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b want 0", bus.resp_ready_o); end
      checks++; if ({bus.int_wb_v_o, bus.float_wb_v_o, bus.icache_v_o} !== 3'b000) begin errors++; $display("FAIL rst_valids: got %b want 000", {bus.int_wb_v_o, bus.float_wb_v_o, bus.icache_v_o}); end
      checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", bus.outstanding_o); end
      reset_n = 1;
      step();
      checks++; if (bus.resp_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", bus.resp_ready_o); end
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got %b want 1", bus.idle_o); end
      checks++; if (bus.outstanding_full_o !== 1'b0) begin errors++; $display("FAIL post_rst_full: got %b want 0", bus.outstanding_full_o); end
   endtask

   task automatic test_signed_byte();
      send_loads(1);
      push(32'h80FF7F01, 7'b0001010, 5'd5, "sbyte");
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.int_wb_v_o !== 1'b1) begin errors++; $display("FAIL sbyte_hold_v: cycle %0d got %b want 1", i, bus.int_wb_v_o); end
         checks++; if (bus.int_wb_rd_o !== 5'd5) begin errors++; $display("FAIL sbyte_hold_rd: cycle %0d got %0d want 5", i, bus.int_wb_rd_o); end
         checks++; if (bus.int_wb_data_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL sbyte_hold_data: cycle %0d got %h want ffffffff", i, bus.int_wb_data_o); end
         step();
      end
      bus.int_wb_yumi_i = bus.int_wb_v_o;
      step();
      bus.int_wb_yumi_i = 0;
      checks++; if (bus.int_wb_v_o !== 1'b0) begin errors++; $display("FAIL sbyte_deq_v: got %b want 0", bus.int_wb_v_o); end
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL sbyte_deq_idle: got %b want 1", bus.idle_o); end
   endtask

   task automatic test_halves();
      logic [6:0]  infos [3] = '{7'b0010110, 7'b0000110, 7'b0000100};
      logic [31:0] wants [3] = '{32'h00008001, 32'hFFFF8001, 32'h00007FFE};
      for (int i = 0; i < 3; i++) begin
         send_loads(1);
         push(32'h80017FFE, infos[i], 5'd7, "half");
         checks++; if (bus.int_wb_v_o !== 1'b1) begin errors++; $display("FAIL half_v[%0d]: got %b want 1", i, bus.int_wb_v_o); end
         checks++; if (bus.int_wb_data_o !== wants[i]) begin errors++; $display("FAIL half_data[%0d]: got %h want %h", i, bus.int_wb_data_o, wants[i]); end
         bus.int_wb_yumi_i = bus.int_wb_v_o;
         step();
         bus.int_wb_yumi_i = 0;
      end
   endtask

   task automatic test_steering();
      send_loads(2);
      push(32'hDEADBEEF, 7'b1100000, 5'd9, "steer_ic");
      push(32'h12345678, 7'b1000000, 5'd3, "steer_fp");
      checks++; if ({bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o} !== 3'b100) begin errors++; $display("FAIL steer_icache_only: got %b want 100", {bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o}); end
      checks++; if (bus.icache_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL steer_icache_data: got %h want deadbeef", bus.icache_data_o); end
      bus.icache_yumi_i = bus.icache_v_o;
      step();
      bus.icache_yumi_i = 0;
      checks++; if ({bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o} !== 3'b010) begin errors++; $display("FAIL steer_float_only: got %b want 010", {bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o}); end
      checks++; if (bus.float_wb_rd_o !== 5'd3) begin errors++; $display("FAIL steer_float_rd: got %0d want 3", bus.float_wb_rd_o); end
      checks++; if (bus.float_wb_data_o !== 32'h12345678) begin errors++; $display("FAIL steer_float_data: got %h want 12345678", bus.float_wb_data_o); end
      bus.float_wb_yumi_i = bus.float_wb_v_o;
      step();
      bus.float_wb_yumi_i = 0;
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL steer_idle: got %b want 1", bus.idle_o); end
   endtask

   task automatic test_x0_drop();
      send_loads(1);
      checks++; if (bus.outstanding_o !== 5'd1) begin errors++; $display("FAIL x0_out_before: got %0d want 1", bus.outstanding_o); end
      push(32'hCAFEF00D, info_word, 5'd0, "x0");
      checks++; if ({bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o} !== 3'b000) begin errors++; $display("FAIL x0_no_valid: got %b want 000", {bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o}); end
      checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL x0_out_after: got %0d want 0", bus.outstanding_o); end
      checks++; if (bus.idle_o !== 1'b0) begin errors++; $display("FAIL x0_buffered: idle got %b want 0", bus.idle_o); end
      step();
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL x0_drained: idle got %b want 1", bus.idle_o); end
   endtask

   task automatic test_back_to_back();
      send_loads(3);
      bus.resp_v_i = 1; bus.resp_load_info_i = info_word;
      bus.resp_data_i = 32'h11111111; bus.resp_reg_id_i = 5'd1; step();
      bus.resp_data_i = 32'h22222222; bus.resp_reg_id_i = 5'd2; step();
      checks++; if (bus.resp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full: ready got %b want 0", bus.resp_ready_o); end
      bus.resp_data_i = 32'h33333333; bus.resp_reg_id_i = 5'd3; step();
      checks++; if (bus.resp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_still_full: ready got %b want 0", bus.resp_ready_o); end
      checks++; if (bus.int_wb_data_o !== 32'h11111111) begin errors++; $display("FAIL bp_head_a: got %h want 11111111", bus.int_wb_data_o); end
      bus.int_wb_yumi_i = bus.int_wb_v_o; step(); bus.int_wb_yumi_i = 0;
      checks++; if (bus.resp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: ready got %b want 1", bus.resp_ready_o); end
      checks++; if (bus.int_wb_data_o !== 32'h22222222) begin errors++; $display("FAIL bp_head_b: got %h want 22222222", bus.int_wb_data_o); end
      step();
      bus.resp_v_i = 0;
      checks++; if (bus.int_wb_rd_o !== 5'd2) begin errors++; $display("FAIL bp_head_b_rd: got %0d want 2", bus.int_wb_rd_o); end
      bus.int_wb_yumi_i = bus.int_wb_v_o; step(); bus.int_wb_yumi_i = 0;
      checks++; if (bus.int_wb_data_o !== 32'h33333333) begin errors++; $display("FAIL bp_head_c: got %h want 33333333", bus.int_wb_data_o); end
      bus.int_wb_yumi_i = bus.int_wb_v_o; step(); bus.int_wb_yumi_i = 0;
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL bp_idle: got %b want 1", bus.idle_o); end
   endtask

   task automatic test_counter();
      send_loads(16);
      checks++; if (bus.outstanding_o !== 5'd16) begin errors++; $display("FAIL cnt_16: got %0d want 16", bus.outstanding_o); end
      checks++; if (bus.outstanding_full_o !== 1'b1) begin errors++; $display("FAIL cnt_full: got %b want 1", bus.outstanding_full_o); end
      push(32'hAAAA5555, info_word, 5'd4, "cnt_a");
      checks++; if (bus.outstanding_o !== 5'd15) begin errors++; $display("FAIL cnt_15: got %0d want 15", bus.outstanding_o); end
      bus.load_sent_i = 1;
      push(32'h5555AAAA, info_word, 5'd6, "cnt_b");
      bus.load_sent_i = 0;
      checks++; if (bus.outstanding_o !== 5'd15) begin errors++; $display("FAIL cnt_same: got %0d want 15", bus.outstanding_o); end
      checks++; if (bus.int_wb_v_o !== 1'b1) begin errors++; $display("FAIL cnt_buffered_v: got %b want 1", bus.int_wb_v_o); end
      reset_n = 0;
      step();
      checks++; if ({bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o} !== 3'b000) begin errors++; $display("FAIL midrst_valids: got %b want 000", {bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o}); end
      checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL midrst_out: got %0d want 0", bus.outstanding_o); end
      checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b want 1", bus.idle_o); end
      reset_n = 1;
      step();
      checks++; if (bus.int_wb_v_o !== 1'b0) begin errors++; $display("FAIL midrst_discard: int_wb_v got %b want 0", bus.int_wb_v_o); end
      checks++; if (bus.resp_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.resp_ready_o); end
   endtask

   task automatic test_random();
      ent_t mq[$];
      ent_t h, e;
      int   m_cnt = 0;
      logic exp_c, exp_f, exp_i, x0, ls, rv, do_enq, do_deq;
      reset_n = 0; step(); reset_n = 1; step();
      for (int cyc = 0; cyc < 400; cyc++) begin
         exp_c = 0; exp_f = 0; exp_i = 0; x0 = 0;
         h = '{data: '0, info: '0, rd: '0};
         if (mq.size() > 0) begin
            h = mq[0];
            exp_c = h.info[5];
            exp_f = !h.info[5] && h.info[6];
            exp_i = !h.info[5] && !h.info[6] && h.rd != 0;
            x0    = !h.info[5] && !h.info[6] && h.rd == 0;
         end
         checks++; if ({bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o} !== {exp_c, exp_f, exp_i}) begin errors++; $display("FAIL rnd_valids: cyc %0d got %b want %b", cyc, {bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o}, {exp_c, exp_f, exp_i}); end
         if (exp_c) begin
            checks++; if (bus.icache_data_o !== h.data) begin errors++; $display("FAIL rnd_icache_data: cyc %0d got %h want %h", cyc, bus.icache_data_o, h.data); end
         end
         if (exp_f) begin
            checks++; if ({bus.float_wb_rd_o, bus.float_wb_data_o} !== {h.rd, h.data}) begin errors++; $display("FAIL rnd_float: cyc %0d got %0d/%h want %0d/%h", cyc, bus.float_wb_rd_o, bus.float_wb_data_o, h.rd, h.data); end
         end
         if (exp_i) begin
            checks++; if ({bus.int_wb_rd_o, bus.int_wb_data_o} !== {h.rd, ref_fmt(h.data, h.info)}) begin errors++; $display("FAIL rnd_int: cyc %0d got %0d/%h want %0d/%h", cyc, bus.int_wb_rd_o, bus.int_wb_data_o, h.rd, ref_fmt(h.data, h.info)); end
         end
         checks++; if (bus.resp_ready_o !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, bus.resp_ready_o, mq.size() < 2); end
         checks++; if (bus.outstanding_o !== cw'(m_cnt)) begin errors++; $display("FAIL rnd_outstanding: cyc %0d got %0d want %0d", cyc, bus.outstanding_o, m_cnt); end
         checks++; if ({bus.outstanding_full_o, bus.idle_o} !== {m_cnt == max_out, mq.size() == 0 && m_cnt == 0}) begin errors++; $display("FAIL rnd_full_idle: cyc %0d got %b want %b", cyc, {bus.outstanding_full_o, bus.idle_o}, {m_cnt == max_out, mq.size() == 0 && m_cnt == 0}); end

         ls = (m_cnt < max_out) && ($urandom_range(0, 2) == 0);
         rv = (m_cnt > 0) && ($urandom_range(0, 1) == 0);
         e.data = $urandom;
         e.rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         case ($urandom_range(0, 2))
            0:       e.info[3:2] = 2'b10;
            1:       e.info[3:2] = 2'b01;
            default: e.info[3:2] = 2'b00;
         endcase
         e.info[6]   = ($urandom_range(0, 2) == 0);
         e.info[5]   = ($urandom_range(0, 3) == 0);
         e.info[4]   = 1'($urandom_range(0, 1));
         e.info[1:0] = 2'($urandom_range(0, 3));
         bus.load_sent_i = ls; bus.resp_v_i = rv;
         bus.resp_data_i = e.data; bus.resp_load_info_i = e.info; bus.resp_reg_id_i = e.rd;
         bus.icache_yumi_i   = bus.icache_v_o   & ($urandom_range(0, 1) == 0);
         bus.float_wb_yumi_i = bus.float_wb_v_o & ($urandom_range(0, 1) == 0);
         bus.int_wb_yumi_i   = bus.int_wb_v_o   & ($urandom_range(0, 1) == 0);
         do_enq = rv && (mq.size() < 2);
         do_deq = x0 || (exp_c && bus.icache_yumi_i) || (exp_f && bus.float_wb_yumi_i) || (exp_i && bus.int_wb_yumi_i);
         step();
         if (do_deq) void'(mq.pop_front());
         if (do_enq) mq.push_back(e);
         m_cnt = m_cnt + int'(ls) - int'(do_enq);
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_signed_byte();
      test_halves();
      test_steering();
      test_x0_drop();
      test_back_to_back();
      test_counter();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
